// File: rtl/frame_relay_pkg.sv
// Shared types and helpers for the serial frame relay.
// Receive/transmit state encodings and a constant clog2.
package frame_relay_pkg;

    typedef enum logic [1:0] {
        RX_HUNT    = 2'd0,
        RX_COLLECT = 2'd1,
        RX_PARITY  = 2'd2,
        RX_COMMIT  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_LOAD = 2'd1,
        TX_SEND = 2'd2
    } tx_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/relay_fifo.sv
// Synchronous word FIFO between the receive and transmit FSMs.
// Head word is visible on rdata; a push while full is refused.
module relay_fifo
    import frame_relay_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [clog2(DEPTH):0] count
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage array; no reset needed, occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serial_frame_relay.sv
// Bit-serial frame receiver, word FIFO and re-serialiser.
// Receive and transmit FSMs run concurrently around relay_fifo.
module serial_frame_relay
    import frame_relay_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                PAT_W     = 4,
    parameter logic [PAT_W-1:0]  START_PAT = 4'b1011,
    parameter bit                PARITY_EN = 1'b1,
    parameter int                DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sin,
    input  logic                     sin_en,
    output logic                     sout,
    output logic                     sout_valid,
    input  logic                     sout_ready,
    output logic                     frame_done,
    output logic                     parity_err,
    output logic                     drop,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     rx_busy
);

    localparam int BW = clog2(DATA_W);

    rx_state_t         rx_state;
    logic [PAT_W-1:0]  win;
    logic [PAT_W-1:0]  win_next;
    logic [DATA_W-1:0] rx_data;
    logic [BW-1:0]     rx_cnt;

    tx_state_t         tx_state;
    logic [DATA_W-1:0] sr;
    logic [BW-1:0]     tx_cnt;

    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] head;

    assign win_next = PAT_W'({win, sin});
    assign push     = (rx_state == RX_COMMIT);
    assign pop      = (tx_state == TX_LOAD);
    assign rx_busy  = (rx_state != RX_HUNT);
    assign sout     = sout_valid & sr[0];

    relay_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .wdata(rx_data),
        .pop  (pop),
        .rdata(head),
        .full (full),
        .empty(empty),
        .count(fifo_count)
    );

    // Receive FSM: hunt start pattern, collect payload, check parity, commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state   <= RX_HUNT;
            win        <= '0;
            rx_data    <= '0;
            rx_cnt     <= '0;
            parity_err <= 1'b0;
            drop       <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            drop       <= 1'b0;
            unique case (rx_state)
                RX_HUNT: begin
                    if (sin_en) begin
                        if (win_next == START_PAT) begin
                            rx_state <= RX_COLLECT;
                            rx_cnt   <= '0;
                            win      <= '0;
                        end else begin
                            win <= win_next;
                        end
                    end
                end
                RX_COLLECT: begin
                    if (sin_en) begin
                        rx_data <= {sin, rx_data[DATA_W-1:1]};
                        rx_cnt  <= rx_cnt + 1'b1;
                        if (rx_cnt == BW'(DATA_W - 1)) begin
                            rx_state <= PARITY_EN ? RX_PARITY : RX_COMMIT;
                        end
                    end
                end
                RX_PARITY: begin
                    if (sin_en) begin
                        if ((^rx_data) ^ sin) begin
                            parity_err <= 1'b1;
                            rx_state   <= RX_HUNT;
                        end else begin
                            rx_state <= RX_COMMIT;
                        end
                    end
                end
                RX_COMMIT: begin
                    drop     <= full;
                    rx_state <= RX_HUNT;
                end
                default: rx_state <= RX_HUNT;
            endcase
        end
    end

    // Transmit FSM: pop a word, shift it out LSB first under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state   <= TX_IDLE;
            sr         <= '0;
            tx_cnt     <= '0;
            sout_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (tx_state)
                TX_IDLE: begin
                    if (!empty) tx_state <= TX_LOAD;
                end
                TX_LOAD: begin
                    sr         <= head;
                    tx_cnt     <= '0;
                    sout_valid <= 1'b1;
                    tx_state   <= TX_SEND;
                end
                TX_SEND: begin
                    if (sout_ready) begin
                        sr     <= sr >> 1;
                        tx_cnt <= tx_cnt + 1'b1;
                        if (tx_cnt == BW'(DATA_W - 1)) begin
                            sout_valid <= 1'b0;
                            frame_done <= 1'b1;
                            tx_state   <= TX_IDLE;
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_relay.sv
// Directed bench for serial_frame_relay (8-bit, 1011, even parity, depth 4).
// Inputs change on the falling edge; a monitor rebuilds output words.
module tb_serial_frame_relay;

    logic       clk = 1'b0;
    logic       rst;
    logic       sin;
    logic       sin_en;
    logic       sout;
    logic       sout_valid;
    logic       sout_ready;
    logic       frame_done;
    logic       parity_err;
    logic       drop;
    logic [2:0] fifo_count;
    logic       rx_busy;

    int errs   = 0;
    int checks = 0;

    logic [7:0] words[$];
    logic [7:0] acc = '0;
    int nbit    = 0;
    int n_done  = 0;
    int n_perr  = 0;
    int n_drop  = 0;
    int n_valid = 0;

    serial_frame_relay #(
        .DATA_W   (8),
        .PAT_W    (4),
        .START_PAT(4'b1011),
        .PARITY_EN(1'b1),
        .DEPTH    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .sin_en    (sin_en),
        .sout      (sout),
        .sout_valid(sout_valid),
        .sout_ready(sout_ready),
        .frame_done(frame_done),
        .parity_err(parity_err),
        .drop      (drop),
        .fifo_count(fifo_count),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    // Rebuild transmitted words and count output pulses.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            nbit = 0;
        end else begin
            if (sout_valid) n_valid++;
            if (frame_done) n_done++;
            if (parity_err) n_perr++;
            if (drop) n_drop++;
            if (sout_valid && sout_ready) begin
                acc = {sout, acc[7:1]};
                nbit++;
                if (nbit == 8) begin
                    words.push_back(acc);
                    nbit = 0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        sin    = b;
        sin_en = 1'b1;
        @(negedge clk);
        sin_en = 1'b0;
        sin    = 1'b0;
    endtask

    task automatic send_seq(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
    endtask

    task automatic send_payload(input logic [7:0] w);
        for (int i = 0; i < 8; i++) send_bit(w[i]);
    endtask

    task automatic send_frame(input logic [7:0] w, input logic p);
        send_seq(16'b1011, 4);
        send_payload(w);
        send_bit(p);
    endtask

    task automatic wait_words(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (words.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        #2;
        check(tag, words.size(), n);
    endtask

    task automatic check_quiet(input string tag);
        check(tag, {sout, sout_valid, frame_done, parity_err, drop,
                    rx_busy, fifo_count}, 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int d0;
        int k;
        logic [7:0] w;

        rst        = 1'b1;
        sin        = 1'b0;
        sin_en     = 1'b0;
        sout_ready = 1'b0;
        #1;
        check_quiet("reset_outputs");
        cyc(2);
        rst = 1'b0;

        // 1: good frame 0xA5, latency and bit order
        sout_ready = 1'b1;
        base = words.size();
        d0   = n_done;
        send_frame(8'hA5, 1'b0);
        #2;
        check("t1_commit_valid", sout_valid, 1'b0);
        cyc(2);
        #2;
        check("t1_load_valid", sout_valid, 1'b0);
        cyc(1);
        #2;
        check("t1_send_valid", sout_valid, 1'b1);
        check("t1_first_bit", sout, 1'b1);
        wait_words("t1_count", base + 1, 60);
        check("t1_word", words[base], 8'hA5);
        cyc(3);
        #2;
        check("t1_done", n_done - d0, 1);

        // 2: bad parity is discarded
        d0   = n_valid;
        k    = n_perr;
        send_frame(8'hA5, 1'b1);
        cyc(6);
        #2;
        check("t2_perr", n_perr - k, 1);
        check("t2_count", fifo_count, 3'd0);
        check("t2_no_valid", n_valid - d0, 0);
        check("t2_busy", rx_busy, 1'b0);

        // 3: overflow under full backpressure
        cyc(1);
        sout_ready = 1'b0;
        base = words.size();
        d0   = n_drop;
        for (int i = 1; i <= 7; i++) begin
            w = 8'(i);
            send_frame(w, ^w);
        end
        cyc(4);
        #2;
        check("t3_full", fifo_count, 3'd4);
        check("t3_drops", n_drop - d0, 2);
        check("t3_hold_valid", sout_valid, 1'b1);
        check("t3_hold_bit", sout, 1'b1);
        cyc(1);
        sout_ready = 1'b1;
        wait_words("t3_count", base + 5, 200);
        for (int i = 0; i < 5; i++) check("t3_order", words[base + i], i + 1);
        cyc(4);
        #2;
        check("t3_drained", fifo_count, 3'd0);

        // 4: commit lands in the same cycle as a LOAD
        cyc(1);
        sout_ready = 1'b0;
        base = words.size();
        send_frame(8'h10, 1'b1);
        send_frame(8'h20, 1'b1);
        send_frame(8'h30, 1'b0);
        send_frame(8'h40, 1'b1);
        cyc(4);
        #2;
        check("t4_prefill", fifo_count, 3'd3);
        send_seq(16'b1011, 4);
        send_payload(8'h55);
        #2;
        check("t4_wait_par", rx_busy, 1'b1);
        d0 = n_drop;
        cyc(1);
        sout_ready = 1'b1;
        k = 0;
        while (!frame_done && k < 100) begin
            @(negedge clk);
            k++;
        end
        sin    = 1'b0;
        sin_en = 1'b1;
        check("t4_align", k < 100, 1'b1);
        @(negedge clk);
        sin_en = 1'b0;
        #2;
        check("t4_cnt_load", fifo_count, 3'd3);
        cyc(1);
        #2;
        check("t4_cnt_after", fifo_count, 3'd3);
        check("t4_no_drop", n_drop - d0, 0);
        wait_words("t4_count", base + 5, 300);
        check("t4_w0", words[base + 0], 8'h10);
        check("t4_w1", words[base + 1], 8'h20);
        check("t4_w2", words[base + 2], 8'h30);
        check("t4_w3", words[base + 3], 8'h40);
        check("t4_w4", words[base + 4], 8'h55);

        // 5: pattern only in hunt; payload 0xBB contains 1011
        base = words.size();
        send_seq(16'b1101, 4);
        #2;
        check("t5_no_start", rx_busy, 1'b0);
        send_bit(1'b1);
        #2;
        check("t5_start", rx_busy, 1'b1);
        send_payload(8'hBB);
        send_bit(1'b0);
        send_seq(16'b011, 3);
        #2;
        check("t5_idle", rx_busy, 1'b0);
        wait_words("t5_count", base + 1, 60);
        check("t5_word", words[base], 8'hBB);
        cyc(30);
        #2;
        check("t5_single", words.size(), base + 1);

        // 6: reset mid-COLLECT and mid-SEND
        send_seq(16'b1011, 4);
        send_seq(16'b101, 3);
        #2;
        check("t6_collect", rx_busy, 1'b1);
        rst = 1'b1;
        #1;
        check_quiet("t6_rst_rx");
        cyc(2);
        rst        = 1'b0;
        sout_ready = 1'b0;
        send_frame(8'h81, 1'b0);
        send_frame(8'h42, 1'b0);
        cyc(4);
        #2;
        check("t6_pending", fifo_count, 3'd1);
        check("t6_sending", sout_valid, 1'b1);
        d0 = n_done + n_perr + n_drop;
        rst = 1'b1;
        #1;
        check_quiet("t6_rst_tx");
        cyc(2);
        rst = 1'b0;
        cyc(3);
        #2;
        check("t6_no_pulse", n_done + n_perr + n_drop - d0, 0);
        cyc(1);
        sout_ready = 1'b1;
        base = words.size();
        send_frame(8'h3C, 1'b0);
        wait_words("t6_count", base + 1, 60);
        check("t6_word", words[base], 8'h3C);
        cyc(20);
        #2;
        check("t6_single", words.size(), base + 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
